// File: rtl/dsp_pkg.sv
// Shared definitions for the FIR tap sequencer: default widths, FSM states and
// width helpers used to size ports and localparams.
package dsp_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    START,
    WAIT,
    NEXT,
    OUT
  } fir_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Enough headroom to add `taps` full-width products without overflow.
  function automatic int sum_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write per accepted sample, combinational read of
// x[n-k] addressed by tap index k relative to the most recent write.
module fir_delay_line
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAPS       = 4,
  localparam int AW        = idx_width(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         tap,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [TAPS];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW:0]           rd_sum;
  logic [AW:0]           rd_idx;

  // (wr_ptr - 1 - tap) mod TAPS without a divider; works for any TAPS.
  always_comb begin
    rd_sum = {1'b0, wr_ptr_reg} + (AW+1)'(TAPS - 1) - {1'b0, tap};
    rd_idx = (rd_sum >= (AW+1)'(TAPS)) ? rd_sum - (AW+1)'(TAPS) : rd_sum;
  end

  assign rd_data = mem_reg[rd_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      for (int i = 0; i < TAPS; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_ptr_reg] <= wr_data;
      wr_ptr_reg <= (wr_ptr_reg == AW'(TAPS - 1)) ? '0 : wr_ptr_reg + AW'(1);
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Drives an external shift-add MAC once per tap and accumulates the products
// into one unsigned FIR output per accepted sample.
module fir_tap_sequencer
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TAPS       = 4,
  parameter int TIMEOUT    = 64,
  localparam int AW        = idx_width(TAPS),
  localparam int SUM_WIDTH = sum_width(DATA_WIDTH, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_addr,
  input  logic [DATA_WIDTH-1:0]   coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_WIDTH-1:0]    out_data,
  output logic                    err,
  output logic                    mac_clr,
  output logic                    mac_start,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic                    mac_done,
  input  logic [2*DATA_WIDTH-1:0] mac_acc
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fir_state_t            state_reg, state_next;
  logic [AW-1:0]         tap_reg;
  logic [TW-1:0]         timer_reg;
  logic [SUM_WIDTH-1:0]  sum_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] mac_a_reg, mac_b_reg;
  logic [DATA_WIDTH-1:0] coef_mem [TAPS];
  logic [DATA_WIDTH-1:0] sample;
  logic                  accept;
  logic                  timed_out;
  logic                  last_tap;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign timed_out = (timer_reg == TW'(TIMEOUT - 1));
  assign last_tap  = (tap_reg == AW'(TAPS - 1));

  fir_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data),
    .tap     (tap_reg),
    .rd_data (sample)
  );

  // Coefficients change only between samples; a write in the accept cycle
  // lands before CLR reads it, so it applies to that very sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) coef_mem[i] <= '0;
    end else if (state_reg == IDLE && coef_we && 32'(coef_addr) < TAPS) begin
      coef_mem[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mac_clr    = 1'b0;
    mac_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CLR;
      end
      CLR: begin
        mac_clr    = 1'b1;
        state_next = START;
      end
      START: begin
        mac_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (mac_done || timed_out) state_next = NEXT;
      NEXT:    state_next = last_tap ? OUT : CLR;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched in CLR so they stay put from START through WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tap_reg   <= '0;
      timer_reg <= '0;
      sum_reg   <= '0;
      err_reg   <= 1'b0;
      mac_a_reg <= '0;
      mac_b_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            tap_reg <= '0;
            sum_reg <= '0;
          end
        end
        CLR: begin
          mac_a_reg <= sample;
          mac_b_reg <= coef_mem[tap_reg];
          timer_reg <= '0;
        end
        WAIT: begin
          if (mac_done)       sum_reg   <= sum_reg + SUM_WIDTH'(mac_acc);
          else if (timed_out) err_reg   <= 1'b1;
          else                timer_reg <= timer_reg + TW'(1);
        end
        NEXT: begin
          if (!last_tap) tap_reg <= tap_reg + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = sum_reg;
  assign err      = err_reg;
  assign mac_a    = mac_a_reg;
  assign mac_b    = mac_b_reg;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench: a MAC stub with variable latency plus a
// direct-sum FIR model of the expected outputs.
module tb_fir_tap_sequencer;

  localparam int DW      = 16;
  localparam int TAPS    = 4;
  localparam int TIMEOUT = 64;
  localparam int AW      = 2;
  localparam int SW      = 2 * DW + 2;
  localparam int BOUND   = TAPS * (TIMEOUT + 8) + 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_data;
  logic          err;
  logic          mac_clr;
  logic          mac_start;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_done = 1'b0;
  logic [2*DW-1:0] mac_acc = '0;

  always #5 clk = ~clk;

  fir_tap_sequencer #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .mac_clr   (mac_clr),
    .mac_start (mac_start),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_done  (mac_done),
    .mac_acc   (mac_acc)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: h_m[k] = h[k], x_m[k] = x[n-k].
  logic [DW-1:0] h_m [TAPS];
  logic [DW-1:0] x_m [TAPS];
  logic [SW-1:0] exp_y = '0;
  bit            exp_err = 1'b0;
  bit            mac_dead = 1'b0;
  int            mac_lat = 2;
  int            starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [SW-1:0] fir_model();
    logic [SW-1:0] s = '0;
    for (int k = 0; k < TAPS; k++) s += SW'(h_m[k]) * SW'(x_m[k]);
    return s;
  endfunction

  // MAC stub: captures operands on start, answers after mac_lat cycles.
  logic [2*DW-1:0] pend_prod = '0;
  int  mac_cnt = 0;
  bit  mac_busy = 1'b0;
  always @(posedge clk) begin
    if (!rst || mac_clr) begin
      mac_done <= 1'b0;
      mac_acc  <= '0;
      mac_busy <= 1'b0;
    end else if (mac_start) begin
      mac_busy  <= 1'b1;
      mac_cnt   <= mac_lat;
      pend_prod <= (2*DW)'(mac_a) * (2*DW)'(mac_b);
    end else if (mac_busy) begin
      if (mac_cnt <= 1 && !mac_dead) begin
        mac_done <= 1'b1;
        mac_acc  <= pend_prod;
        mac_busy <= 1'b0;
      end else if (mac_cnt > 1) begin
        mac_cnt <= mac_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (rst && mac_start) starts++;

  // Per-cycle compare whenever a result is presented.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      check("out_data", out_data, exp_y);
      check("in_ready_busy", in_ready, 1'b0);
      check("err", err, exp_err);
    end
  end

  task automatic write_coef(input int addr, input logic [DW-1:0] data);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = data;
    h_m[addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic accept(input logic [DW-1:0] x, input bit cw, input int caddr,
                        input logic [DW-1:0] cdata);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_data = x;
    coef_we = cw; coef_addr = AW'(caddr); coef_data = cdata;
    if (cw) h_m[caddr] = cdata;
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = x;
    if (mac_dead) begin
      exp_y = '0;
      exp_err = 1'b1;
    end else begin
      exp_y = fir_model();
    end
    starts = 0;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic finish(input int hold, output logic [SW-1:0] y);
    int n = 0;
    while (!out_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0 want 1 within %0d cycles", BOUND);
    end
    repeat (hold) @(negedge clk);
    y = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1'b1);
    check("mac_starts", starts, TAPS);
  endtask

  // A sample, with a coefficient write while busy that must be dropped.
  task automatic run_sample(input logic [DW-1:0] x, input int hold, input bit cw,
                            input int caddr, input logic [DW-1:0] cdata,
                            output logic [SW-1:0] y);
    accept(x, cw, caddr, cdata);
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'd9;
    @(negedge clk);
    coef_we = 1'b0;
    finish(hold, y);
    $display("sample x=%0h y=%0h", x, y);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      h_m[k] = '0;
      x_m[k] = '0;
    end
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_err", err, 1'b0);
    check("rst_mac_clr", mac_clr, 1'b0);
    check("rst_mac_start", mac_start, 1'b0);
    check("rst_mac_a", mac_a, '0);
    check("rst_mac_b", mac_b, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  logic [SW-1:0] y;
  logic [SW-1:0] imp_exp [5];

  initial begin
    imp_exp[0] = SW'(1); imp_exp[1] = SW'(2); imp_exp[2] = SW'(3);
    imp_exp[3] = SW'(4); imp_exp[4] = SW'(0);
    @(negedge clk);
    do_reset();

    // Impulse response.
    for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? DW'(1) : DW'(0), 0, 1'b0, 0, '0, y);
      check("impulse", y, imp_exp[i]);
    end

    // Full-scale sum, result held 20 cycles before acceptance.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'hFFFF);
    for (int i = 0; i < 4; i++) run_sample(16'hFFFF, (i == 3) ? 20 : 0, 1'b0, 0, '0, y);
    check("full_scale", y, 34'h3_FFF8_0004);

    // Coefficient write in the accept cycle is used immediately.
    run_sample(16'd2, 0, 1'b1, 0, 16'd5, y);
    check("same_cycle_coef", y, SW'(5 * 2 + 3 * 16'hFFFF * 16'hFFFF));

    // Randomized samples, coefficients, MAC latency and backpressure.
    for (int i = 0; i < 24; i++) begin
      mac_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) write_coef($urandom_range(0, TAPS - 1), DW'($urandom));
      run_sample(DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                 $urandom_range(0, TAPS - 1), DW'($urandom), y);
    end
    mac_lat = 2;

    // Reset during the third tap's wait abandons the sample.
    for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
    accept(16'd7, 1'b0, 0, '0);
    begin
      int n = 0;
      while (starts < 3 && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      check("reach_tap2", starts, 3);
    end
    @(negedge clk);
    do_reset();
    check("no_partial_out", out_valid, 1'b0);
    for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
    run_sample(16'd1, 0, 1'b0, 0, '0, y);
    check("impulse_after_rst", y, SW'(1));

    // MAC never answers: every tap times out, sum stays 0, err sticks.
    mac_dead = 1'b1;
    run_sample(16'd3, 0, 1'b0, 0, '0, y);
    check("timeout_y", y, SW'(0));
    check("timeout_err", err, 1'b1);
    mac_dead = 1'b0;
    run_sample(16'd1, 0, 1'b0, 0, '0, y);
    check("after_timeout_y", y, SW'(1 * 1 + 2 * 3 + 3 * 1));
    check("err_sticky", err, 1'b1);
    do_reset();
    check("err_cleared", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Upstream sequencer for `mac_with_adders_16bit` that turns the exact 16-bit shift-add MAC into a TAPS-tap unsigned FIR filter. It accepts one sample at a time over a valid/ready handshake and stores it in a circular delay line. For each tap it clears the MAC, loads the operand pair and pulses start, then waits for done. It sums the TAPS products and presents y[n] = Σ h[k]·x[n−k] on a held valid/ready output.

## Interface
- DATA_WIDTH, 16: sample, coefficient and MAC operand width.
- TAPS, 4: filter length, 2..64.
- TIMEOUT, 64: cycles to wait for mac_done before aborting a tap.
- SUM_WIDTH, 2*DATA_WIDTH+$clog2(TAPS): output width (derived localparam).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  high only in IDLE.
- in_data  in  DATA_WIDTH  unsigned sample x[n].
- coef_we  in  1  coefficient write strobe; honoured only in IDLE.
- coef_addr  in  $clog2(TAPS)  tap index k.
- coef_data  in  DATA_WIDTH  h[k].
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  SUM_WIDTH  y[n].
- err  out  1  sticky MAC-timeout flag, cleared only by reset.
- mac_clr  out  1  one-cycle active-high clear to MAC rst.
- mac_start  out  1  one-cycle start pulse.
- mac_a, mac_b  out  DATA_WIDTH  sample and coefficient operands.
- mac_done  in  1  MAC completion.
- mac_acc  in  2*DATA_WIDTH  MAC product.

## Operation
- All arithmetic is unsigned. Each product is zero-extended to SUM_WIDTH before it is added, so the sum cannot overflow.
- The delay line is a TAPS-deep register array with write pointer wr_ptr. x[n−k] is read at (wr_ptr−1−k) mod TAPS after the write.
- FSM states:
  - IDLE: in_ready=1. On in_valid, write in_data at wr_ptr, increment wr_ptr (wraps TAPS−1→0), set tap=0 and sum=0, go to CLR.
  - CLR: mac_clr=1, go to START.
  - START: mac_start=1, go to WAIT. mac_a and mac_b are held stable from START through WAIT.
  - WAIT: when mac_done=1, set sum += mac_acc. If the timer reaches TIMEOUT first, add nothing and set err. Then go to NEXT.
  - NEXT: if tap==TAPS−1, go to OUT. Otherwise tap++ and go to CLR.
  - OUT: out_valid=1 and out_data=sum, both held stable until out_ready. On accept, go to IDLE.
- A coef_we outside IDLE is dropped. A coef_we and an in_valid accepted in the same IDLE cycle both take effect; the new coefficient is used for this sample.
- Reset values: all outputs 0, state IDLE, wr_ptr 0, delay line 0, coefficients 0, err 0.
- Reset mid-operation abandons the computation; no partial out_valid is produced.

## Timing
- Per tap: 3 cycles (CLR, START, NEXT) plus the MAC latency L measured from start to done.
- Sample accepted → out_valid: TAPS·(3+L)+1 cycles.
- in_ready is low from the accept edge until the cycle after out_valid&out_ready, so there is no overlap and no input buffering.
- Throughput is one sample per TAPS·(3+L)+2 cycles with out_ready held high.

## Structure
- Shared package `dsp_pkg`: DATA_WIDTH default, FSM state enum (IDLE, CLR, START, WAIT, NEXT, OUT), clog2-based width helpers.
- One natural sub-module, `fir_delay_line`: the circular sample buffer with its write pointer and tap-indexed read port.
- `mac_with_adders_16bit` is instantiated beside this block at the next level up, not inside it.

## Test plan
- TAPS=4, h={1,2,3,4}, inputs 1,0,0,0,0 → outputs 1,2,3,4,0 (impulse response, then zero).
- h all 0xFFFF, four inputs of 0xFFFF → fourth output 0x3_FFF8_0004 (full-width sum, no truncation).
- out_ready held low for 20 cycles after out_valid → out_data stable, in_ready=0, no further mac_start; one cycle of out_ready → in_ready=1 next cycle.
- Reset asserted during WAIT of tap 2, then released → all outputs 0, delay line cleared; next impulse with h={1,2,3,4} gives 1.
- MAC stub never raises done → err=1 after TIMEOUT cycles per tap, out_data=0 for that sample, err stays 1 until reset.
- coef_we with addr 0, data 9 pulsed during WAIT → ignored; the next impulse output is still 1.
